csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR register file and trap unit for the 5-stage RV32I core. It consumes the decoder's CSR and privilege controls (CSR write/read enables, CSR operation, CSR address, MRET and exception indicators, and exception cause). It performs atomic read-modify-write on CSRs, keeps 64-bit cycle and instret counters, and on ECALL or MRET produces the PC redirect used by the fetch stage.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec
- HART_ID, 0, value returned by mhartid

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- csr_we  in  1  CSR write enable
- csr_re  in  1  CSR read enable
- csr_op  in  3  CSR funct3 (`CSR_CSRRW..`CSR_CSRRCI)
- csr_addr  in  12  CSR address
- csr_wsrc  in  32  rs1 value (register forms)
- csr_zimm  in  5  rs1 field as zero-extended immediate (immediate forms)
- csr_rdata  out  32  old CSR value, combinational
- csr_illegal  out  1  access to unimplemented CSR, or write to read-only CSR
- exc_valid  in  1  exception from decoder (ECALL)
- exc_cause  in  32  exception cause
- exc_pc  in  32  PC of the faulting instruction
- mret  in  1  MRET executing
- instr_retire  in  1  one instruction retires this cycle
- trap_redirect  out  1  flush and redirect fetch
- trap_target  out  32  redirect PC

## Operation
- Write source: csr_op[2] ? {27'b0, csr_zimm} : csr_wsrc.
- New value by operation:
  - RW: src
  - RS: old | src
  - RC: old & ~src
- A write is committed only when csr_we=1 and csr_illegal=0. csr_illegal also gates csr_rdata to 0.
- Implemented CSRs, all other bits reading 0:
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11.
  - misa 0x301: reads 32'h4000_0100; writes are ignored.
  - mie 0x304.
  - mtvec 0x305: bit 1 forced to 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342.
  - mtval 0x343.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: read-only.
- Read-only rule: csr_we=1 with addr[11:10]==2'b11 asserts csr_illegal, and no state changes.
- Trap entry when exc_valid=1:
  - mepc <= exc_pc & ~3
  - mcause <= exc_cause
  - mtval <= 0
  - MPIE <= MIE, MIE <= 0
  - trap_target = {mtvec[31:2], 2'b00}
- MRET when mret=1:
  - MIE <= MPIE, MPIE <= 1
  - trap_target = mepc
- trap_redirect = exc_valid | mret.
- Priority within one cycle: exc_valid > mret > CSR write. The lower-priority CSR write is dropped.
- Counters:
  - mcycle increments every cycle.
  - minstret increments on instr_retire & ~exc_valid.
  - Both are 64-bit and wrap from all-ones to 0.
  - A CSR write to either half loads that half with the written value. That counter does not increment in that cycle; the other half keeps its value.

## Timing
- Reset (asynchronous, rstn=0):
  - mtvec = MTVEC_RESET; all other state is 0.
  - Outputs while in reset: csr_rdata reflects addressed state, trap_redirect = exc_valid | mret, csr_illegal combinational.
- Reads are combinational and return the pre-edge value; the write commits at the next rising clk edge.
- Back-to-back access to the same CSR: the second read sees the first write, with no forwarding needed.
- trap_redirect and trap_target are combinational in the same cycle; state updates at the following edge.
- Reset asserted mid-trap: all updates abort and registers take reset values immediately.
- exc_valid with mret in the same cycle: trap entry only; mepc is overwritten.

## Structure
- The shared defines file holds:
  - CSR address constants `CSR_ADDR_*
  - cause codes (`CAUSE_ECALL_M = 32'd11)
  - mstatus bit positions
  - the existing `CSR_CSRRW..`CSR_CSRRCI.
- Sub-module csr_counter64 (clk, rstn, inc, we_lo, we_hi, wdata, q[63:0]), instantiated twice: mcycle and minstret.

## Test plan
- Reset with MTVEC_RESET=32'h100 → read 0x305 returns 32'h100; mstatus reads 32'h0000_1800; mhartid reads 0.
- CSRRW 0x340 with src 32'hDEAD_BEEF, then CSRRS with 32'h0000_00F0, then CSRRC with 32'h0000_000F → reads return 0, then DEADBEEF, then DEADBEFF; final value is DEADBEF0.
- Set MIE=1; exc_valid with cause 11, pc 32'h0000_0046 → same cycle: redirect=1, target=mtvec. Next cycle: mepc=32'h44, mcause=11, MIE=0, MPIE=1. Then mret → target=32'h44; MIE=1.
- Write 0xC00, or write 0xF14 with csrrwi → csr_illegal=1 and state unchanged. Read 0x7C0 → csr_illegal=1 and rdata=0.
- Load mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF → two cycles later mcycle=1 and mcycleh=0 (wrap).
- CSR write to mtvec in the same cycle as exc_valid → write dropped; mtvec keeps its old value.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: funct3 encodings, CSR
// addresses, cause codes, mstatus bit positions and the RMW helper.
package csr_file_pkg;

    localparam logic [2:0] CSR_CSRRW  = 3'b001;
    localparam logic [2:0] CSR_CSRRS  = 3'b010;
    localparam logic [2:0] CSR_CSRRC  = 3'b011;
    localparam logic [2:0] CSR_CSRRWI = 3'b101;
    localparam logic [2:0] CSR_CSRRSI = 3'b110;
    localparam logic [2:0] CSR_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_ADDR_MISA      = 12'h301;
    localparam logic [11:0] CSR_ADDR_MIE       = 12'h304;
    localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // op is funct3[1:0]; the immediate/register choice is made before this.
    function automatic logic [31:0] csr_alu(input logic [1:0] op,
                                            input logic [31:0] old,
                                            input logic [31:0] src);
        logic [31:0] r;
        case (op)
            2'b01:   r = src;
            2'b10:   r = old | src;
            2'b11:   r = old & ~src;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit wrapping counter with independently loadable 32-bit halves; a load
// suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            q <= 64'd0;
        else if (we_lo)
            q[31:0] <= wdata;
        else if (we_hi)
            q[63:32] <= wdata;
        else if (inc)
            q <= q + 64'd1;
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit: atomic CSR read-modify-write, 64-bit
// cycle/instret counters, ECALL trap entry and MRET with fetch redirect.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_we,
    input  logic        csr_re,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wsrc,
    input  logic [4:0]  csr_zimm,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret,
    input  logic        instr_retire,
    output logic        trap_redirect,
    output logic [31:0] trap_target
);

    logic        st_mie;
    logic        st_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] old_val;
    logic        hit;
    logic [31:0] src;
    logic [31:0] new_val;
    logic        ro_write;
    logic        commit;

    always_comb begin
        old_val = 32'd0;
        hit     = 1'b1;
        case (csr_addr)
            CSR_ADDR_MSTATUS:  old_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
            CSR_ADDR_MISA:     old_val = MISA_VALUE;
            CSR_ADDR_MIE:      old_val = mie_q;
            CSR_ADDR_MTVEC:    old_val = mtvec_q;
            CSR_ADDR_MSCRATCH: old_val = mscratch_q;
            CSR_ADDR_MEPC:     old_val = mepc_q;
            CSR_ADDR_MCAUSE:   old_val = mcause_q;
            CSR_ADDR_MTVAL:    old_val = mtval_q;
            CSR_ADDR_MCYCLE,
            CSR_ADDR_CYCLE:    old_val = mcycle_q[31:0];
            CSR_ADDR_MCYCLEH,
            CSR_ADDR_CYCLEH:   old_val = mcycle_q[63:32];
            CSR_ADDR_MINSTRET,
            CSR_ADDR_INSTRET:  old_val = minstret_q[31:0];
            CSR_ADDR_MINSTRETH,
            CSR_ADDR_INSTRETH: old_val = minstret_q[63:32];
            CSR_ADDR_MHARTID:  old_val = HART_ID;
            default:           hit = 1'b0;
        endcase
    end

    assign ro_write    = csr_we & (csr_addr[11:10] == 2'b11);
    assign csr_illegal = ((csr_we | csr_re) & ~hit) | ro_write;
    assign csr_rdata   = csr_illegal ? 32'd0 : old_val;

    assign src     = csr_op[2] ? {27'd0, csr_zimm} : csr_wsrc;
    assign new_val = csr_alu(csr_op[1:0], old_val, src);
    // Trap entry and MRET both take priority over, and drop, a CSR write.
    assign commit  = csr_we & ~csr_illegal & ~exc_valid & ~mret;

    assign trap_redirect = exc_valid | mret;
    assign trap_target   = exc_valid ? {mtvec_q[31:2], 2'b00} :
                           mret      ? mepc_q : 32'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else if (exc_valid) begin
            mepc_q   <= exc_pc & ~32'd3;
            mcause_q <= exc_cause;
            mtval_q  <= 32'd0;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (commit) begin
            case (csr_addr)
                CSR_ADDR_MSTATUS: begin
                    st_mie  <= new_val[MSTATUS_MIE];
                    st_mpie <= new_val[MSTATUS_MPIE];
                end
                CSR_ADDR_MIE:      mie_q      <= new_val;
                CSR_ADDR_MTVEC:    mtvec_q    <= new_val & ~32'd2;
                CSR_ADDR_MSCRATCH: mscratch_q <= new_val;
                CSR_ADDR_MEPC:     mepc_q     <= new_val & ~32'd3;
                CSR_ADDR_MCAUSE:   mcause_q   <= new_val;
                CSR_ADDR_MTVAL:    mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (1'b1),
        .we_lo (commit & (csr_addr == CSR_ADDR_MCYCLE)),
        .we_hi (commit & (csr_addr == CSR_ADDR_MCYCLEH)),
        .wdata (new_val),
        .q     (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (instr_retire & ~exc_valid),
        .we_lo (commit & (csr_addr == CSR_ADDR_MINSTRET)),
        .we_hi (commit & (csr_addr == CSR_ADDR_MINSTRETH)),
        .wdata (new_val),
        .q     (minstret_q)
    );

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, RMW ops, trap/MRET, illegal
// accesses, counter load and wrap, and write-vs-trap priority.
module tb_csr_file;

    logic        clk;
    logic        rstn;
    logic        csr_we;
    logic        csr_re;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wsrc;
    logic [4:0]  csr_zimm;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic        mret;
    logic        instr_retire;
    logic        trap_redirect;
    logic [31:0] trap_target;

    int total = 0;
    int bad   = 0;

    csr_file #(.MTVEC_RESET(32'h100), .HART_ID(32'd0)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .csr_we        (csr_we),
        .csr_re        (csr_re),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wsrc      (csr_wsrc),
        .csr_zimm      (csr_zimm),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc),
        .mret          (mret),
        .instr_retire  (instr_retire),
        .trap_redirect (trap_redirect),
        .trap_target   (trap_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        csr_we = 0; csr_re = 0; csr_op = 3'b001; csr_addr = 12'h0;
        csr_wsrc = 0; csr_zimm = 0; exc_valid = 0; exc_cause = 0;
        exc_pc = 0; mret = 0; instr_retire = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic rd(input logic [11:0] a);
        csr_we = 0; csr_re = 1; csr_addr = a;
        #1;
    endtask

    task automatic wr(input logic [2:0] op, input logic [11:0] a,
                      input logic [31:0] s, input logic [4:0] z);
        csr_we = 1; csr_re = 1; csr_op = op; csr_addr = a;
        csr_wsrc = s; csr_zimm = z;
        #1;
    endtask

    initial begin
        clr();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        rd(12'h305); chk("rst_mtvec",   csr_rdata, 32'h100);
        rd(12'h300); chk("rst_mstatus", csr_rdata, 32'h0000_1800);
        rd(12'hF14); chk("rst_mhartid", csr_rdata, 32'h0);
        rd(12'h301); chk("rst_misa",    csr_rdata, 32'h4000_0100);
        clr();
        @(negedge clk) rstn = 1'b1;
        cyc();

        // RMW on mscratch: each read returns the value before that op
        wr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0); chk("rw_old", csr_rdata, 32'h0);
        cyc();
        wr(3'b010, 12'h340, 32'h0000_00F0, 5'd0); chk("rs_old", csr_rdata, 32'hDEAD_BEEF);
        cyc();
        wr(3'b011, 12'h340, 32'h0000_000F, 5'd0); chk("rc_old", csr_rdata, 32'hDEAD_BEFF);
        cyc();
        rd(12'h340); chk("rc_final", csr_rdata, 32'hDEAD_BEF0);
        cyc();

        // minstret counts two retires
        instr_retire = 1; cyc();
        instr_retire = 1; cyc();
        rd(12'hC02); chk("instret", csr_rdata, 32'd2);
        cyc();

        // set MIE with csrrsi, then ECALL trap
        wr(3'b110, 12'h300, 32'h0, 5'd8); cyc();
        rd(12'h300); chk("mie_set", csr_rdata, 32'h0000_1808);
        clr();
        exc_valid = 1; exc_cause = 32'd11; exc_pc = 32'h46;
        #1;
        chk("trap_redir",  {31'd0, trap_redirect}, 32'd1);
        chk("trap_target", trap_target, 32'h100);
        cyc();
        rd(12'h341); chk("mepc",         csr_rdata, 32'h44);
        rd(12'h342); chk("mcause",       csr_rdata, 32'd11);
        rd(12'h300); chk("mstatus_trap", csr_rdata, 32'h0000_1880);
        clr();
        mret = 1;
        #1;
        chk("mret_redir",  {31'd0, trap_redirect}, 32'd1);
        chk("mret_target", trap_target, 32'h44);
        cyc();
        rd(12'h300); chk("mstatus_mret", csr_rdata, 32'h0000_1888);
        cyc();

        // read-only and unimplemented accesses
        wr(3'b101, 12'hF14, 32'h0, 5'd5);
        chk("ro_hartid_ill", {31'd0, csr_illegal}, 32'd1);
        chk("ill_rdata",     csr_rdata, 32'd0);
        cyc();
        rd(12'hF14); chk("hartid_kept", csr_rdata, 32'd0);
        chk("hartid_rd_ok", {31'd0, csr_illegal}, 32'd0);
        rd(12'h7C0);
        chk("unimpl_ill",   {31'd0, csr_illegal}, 32'd1);
        chk("unimpl_rdata", csr_rdata, 32'd0);
        cyc();

        // mcycle load holds for the load cycle; write to cycle shadow ignored
        wr(3'b001, 12'hB00, 32'h10, 5'd0); cyc();
        rd(12'hB00); chk("mcycle_load", csr_rdata, 32'h10);
        wr(3'b001, 12'hC00, 32'hFFFF, 5'd0);
        chk("ro_cycle_ill", {31'd0, csr_illegal}, 32'd1);
        cyc();
        rd(12'hB00); chk("mcycle_inc", csr_rdata, 32'h11);
        cyc();

        // 64-bit wrap
        wr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0); cyc();
        wr(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0); cyc();
        rd(12'hB80); chk("mcycleh_load", csr_rdata, 32'hFFFF_FFFF);
        cyc();
        cyc();
        rd(12'hB00); chk("wrap_lo", csr_rdata, 32'd1);
        rd(12'hB80); chk("wrap_hi", csr_rdata, 32'd0);
        cyc();

        // mtvec bit 1 forced low
        wr(3'b001, 12'h305, 32'h203, 5'd0); cyc();
        rd(12'h305); chk("mtvec_mask", csr_rdata, 32'h201);
        clr();

        // write + exc + mret + retire in one cycle: trap only
        wr(3'b001, 12'h305, 32'h400, 5'd0);
        exc_valid = 1; exc_cause = 32'd11; exc_pc = 32'h88; mret = 1; instr_retire = 1;
        #1;
        chk("prio_redir",  {31'd0, trap_redirect}, 32'd1);
        chk("prio_target", trap_target, 32'h200);
        cyc();
        rd(12'h305); chk("prio_mtvec",   csr_rdata, 32'h201);
        rd(12'h341); chk("prio_mepc",    csr_rdata, 32'h88);
        rd(12'hC02); chk("prio_instret", csr_rdata, 32'd2);
        rd(12'h300); chk("prio_mstatus", csr_rdata, 32'h0000_1880);
        clr();

        // asynchronous reset in the middle of a trap cycle
        exc_valid = 1; exc_cause = 32'd11; exc_pc = 32'h300;
        #1 rstn = 1'b0;
        #1;
        chk("rst_redir", {31'd0, trap_redirect}, 32'd1);
        rd(12'h305); chk("midrst_mtvec",   csr_rdata, 32'h100);
        rd(12'h341); chk("midrst_mepc",    csr_rdata, 32'h0);
        rd(12'h300); chk("midrst_mstatus", csr_rdata, 32'h0000_1800);
        clr();
        @(negedge clk) rstn = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
